// File: rtl/mem_wb_writeback.sv
// MEM/WB writeback stage: aligns big-endian loads and arbitrates the register-file
// write port between the pipeline and a single-entry buffer for late (auxiliary) writers.
module mem_wb_writeback #(
    parameter int STARVE_LIM = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_valid,
    input  logic        p_reg_write,
    input  logic [4:0]  p_dest,
    input  logic        p_mem_to_reg,
    input  logic [31:0] p_alu_result,
    input  logic [31:0] p_mem_rdata,
    input  logic [2:0]  p_load_type,
    input  logic [1:0]  p_byte_off,
    input  logic        aux_valid,
    input  logic [4:0]  aux_dest,
    input  logic [31:0] aux_data,
    output logic        aux_ready,
    output logic        aux_drop,
    output logic        stall_req,
    output logic        wb_en,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data
);

    localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM_M1_C = CNT_W'(STARVE_LIM - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;

    // Big-endian alignment: byte offset 0 is the most significant byte of the word.
    function automatic logic [31:0] align_load(input logic [31:0] word,
                                               input logic [2:0]  ltype,
                                               input logic [1:0]  off);
        logic [15:0] half_s;
        logic [7:0]  byte_s;
        logic [31:0] res_s;
        half_s = off[1] ? word[15:0] : word[31:16];
        case (off)
            2'd0:    byte_s = word[31:24];
            2'd1:    byte_s = word[23:16];
            2'd2:    byte_s = word[15:8];
            default: byte_s = word[7:0];
        endcase
        case (ltype)
            3'd1:    res_s = {{16{half_s[15]}}, half_s};
            3'd2:    res_s = {16'h0000, half_s};
            3'd3:    res_s = {{24{byte_s[7]}}, byte_s};
            3'd4:    res_s = {24'h000000, byte_s};
            default: res_s = word;
        endcase
        return res_s;
    endfunction

    logic [1:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [4:0]       buf_dest_r, buf_dest_s;
    logic [31:0]      buf_data_r, buf_data_s;
    logic             pipe_elig_s;
    logic             aux_accept_s;
    logic             drop_s;
    logic [31:0]      pipe_data_s;
    logic             wb_en_s;
    logic [4:0]       wb_dest_s;
    logic [31:0]      wb_data_s;

    assign stall_req    = (state_r == ST_FORCE);
    assign aux_ready    = rst_n & (state_r == ST_IDLE);
    assign aux_drop     = drop_s & rst_n;
    assign pipe_elig_s  = p_valid & p_reg_write & (p_dest != 5'd0) & ~stall_req;
    assign aux_accept_s = aux_valid & aux_ready & (aux_dest != 5'd0);
    assign pipe_data_s  = p_mem_to_reg ? align_load(p_mem_rdata, p_load_type, p_byte_off)
                                       : p_alu_result;

    // Arbitration, buffer bookkeeping and next writeback values.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        buf_dest_s = buf_dest_r;
        buf_data_s = buf_data_r;
        drop_s     = 1'b0;
        wb_en_s    = 1'b0;
        wb_dest_s  = wb_dest;
        wb_data_s  = wb_data;
        if (pipe_elig_s) begin
            wb_en_s   = 1'b1;
            wb_dest_s = p_dest;
            wb_data_s = pipe_data_s;
        end else begin
            wb_en_s   = 1'b0;
        end
        case (state_r)
            ST_IDLE: begin
                if (aux_accept_s) begin
                    buf_dest_s = aux_dest;
                    buf_data_s = aux_data;
                    cnt_s      = '0;
                    state_s    = ST_PEND;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (!pipe_elig_s) begin
                    wb_en_s   = 1'b1;
                    wb_dest_s = buf_dest_r;
                    wb_data_s = buf_data_r;
                    cnt_s     = '0;
                    state_s   = ST_IDLE;
                end else if (p_dest == buf_dest_r) begin
                    // Pipeline result supersedes the older buffered value.
                    drop_s    = 1'b1;
                    cnt_s     = '0;
                    state_s   = ST_IDLE;
                end else if (cnt_r >= LIM_M1_C) begin
                    cnt_s     = cnt_r + CNT_W'(1);
                    state_s   = ST_FORCE;
                end else begin
                    cnt_s     = cnt_r + CNT_W'(1);
                    state_s   = ST_PEND;
                end
            end
            ST_FORCE: begin
                wb_en_s   = 1'b1;
                wb_dest_s = buf_dest_r;
                wb_data_s = buf_data_r;
                cnt_s     = '0;
                state_s   = ST_IDLE;
            end
            default: begin
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, buffer and registered writeback port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            buf_dest_r <= 5'd0;
            buf_data_r <= 32'd0;
            wb_en      <= 1'b0;
            wb_dest    <= 5'd0;
            wb_data    <= 32'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            buf_dest_r <= buf_dest_s;
            buf_data_r <= buf_data_s;
            wb_en      <= wb_en_s;
            wb_dest    <= wb_dest_s;
            wb_data    <= wb_data_s;
        end
    end

endmodule
